nwd_dispatch: RTL and testbench
===============================

# nwd_dispatch

Operand-queue and sequencing stage placed directly upstream of the `nwd` GCD core. It accepts 8-bit operand pairs over a valid/ready stream and buffers them in a small FIFO. Each pair is issued to the core with a one-cycle `start` pulse and the core's `ready`/`out` pair is monitored. The result is then presented on a valid/ready result stream. Pairs containing a zero are resolved locally, because the core never terminates on a zero operand.

## Interface
Parameters:
- `DEPTH`, 4: operand FIFO entries; power of two, ≥2.
- `W`, 8: operand/result width; fixed at 8 to match the core.

Ports:
- `clk`  in  1  clock.
- `nrst`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  operand pair offered.
- `in_a`, `in_b`  in  W  operands.
- `in_ready`  out  1  FIFO can accept; equals `!full`.
- `core_start`  out  1  one-cycle start pulse to the core.
- `core_a`, `core_b`  out  W  operands to the core; held stable from issue until capture.
- `core_ready`  in  1  core idle / result valid.
- `core_out`  in  W  core result.
- `res_valid`  out  1  result held in the output register.
- `res_data`  out  W  GCD result.
- `res_ready`  in  1  consumer accepts the result.
- `busy`  out  1  state ≠ IDLE.

## Operation
- FIFO push: on `in_valid && in_ready`. There is no pass-through when full, so `in_ready` = 0 while full even if a pop occurs in the same cycle.
- FSM states and transitions:
  - IDLE: if FIFO not empty, pop the head into `op_a`/`op_b`.
    - If `op_a == 0 || op_b == 0`: `res_data <= op_a | op_b` and go to EMIT (bypass).
    - Otherwise go to ISSUE.
  - ISSUE: `core_start = core_ready` (combinational). The FSM leaves ISSUE only when `core_ready` = 1, and goes to WAIT.
  - WAIT: `core_start` = 0. When `core_ready` = 1, `res_data <= core_out` and go to EMIT. `core_ready` is guaranteed 0 in the first WAIT cycle, so no stale result is captured.
  - EMIT: `res_valid` = 1 and `res_data` is held. On `res_ready`, go to IDLE. No pop happens while in EMIT.
- `core_a`/`core_b` are driven from `op_a`/`op_b` at all times.
- Arithmetic: the only local arithmetic is the zero test and `a | b`. Results are exactly W bits; there is no overflow path.
- Reset values: state IDLE, FIFO empty, `in_ready` = 1, `core_start` = 0, `core_a`/`core_b` = 0, `res_valid` = 0, `res_data` = 0, `busy` = 0.
- Reset mid-operation: all state is discarded and queued pairs are lost. The core shares `nrst`, so both restart idle together.

## Timing
- Push at edge E0: the entry is visible in IDLE in the following cycle.
- Bypass path: `res_valid` rises after edge E1 (1 cycle).
- Core path, equal operands: `core_start` is high after E1, the core loads at E2, `core_ready` returns after E3, and `res_valid` rises after E4.
- Core path, general: `res_valid` rises one cycle after `core_ready` returns.
- Throughput: one result per (core latency + 3) cycles. The EMIT → IDLE → next pop sequence adds 1 cycle after acceptance.
- `res_valid && !res_ready`: output is held indefinitely, FIFO still accepts until full.
- Simultaneous push in IDLE with an empty FIFO: that pair is not popped until the next cycle.

## Structure
- Package `nwd_pkg` holds:
  - the `state_t` enum {IDLE, ISSUE, WAIT, EMIT};
  - `localparam NWD_W = 8`.
- Sub-module `nwd_fifo` is a synchronous FIFO:
  - parameters `DEPTH` and `W2 = 2*W`;
  - status outputs `full`/`empty`;
  - pointers with a wrap bit.
- Top `nwd_dispatch` contains the FSM, operand registers and output register. The `nwd` core is instantiated by the parent, not inside this block.

## Test plan
- Push (48,18), `res_ready` = 1: `core_start` pulses exactly once, `res_data` = 6, `busy` falls after acceptance.
- Push (0,7), then (0,0): results 7 then 0. Neither pair produces `core_start`, and `res_valid` rises 1 cycle after each pop.
- Push (9,9): `res_valid` rises exactly 4 cycles after the push edge, `res_data` = 9.
- Hold `res_ready` = 0 and push 5 pairs with DEPTH = 4: `in_ready` drops once the 4 pairs behind the popped one are queued, and `res_data` stays stable. Release: results drain in order (e.g. 6, 5, 1, 12, 3).
- Assert `nrst` during WAIT of (255,1): all outputs return to reset values and no `res_valid` appears afterwards. A subsequent push of (100,75) yields 25.
- Back-to-back stream of 8 random nonzero pairs with random `res_ready`: results match a reference GCD, order is preserved, and no pair is lost or duplicated.

Source files
------------

// File: rtl/nwd_pkg.sv
// Shared types and constants for the nwd dispatch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nwd_pkg;

    // Operand/result width of the nwd GCD core.
    localparam int NWD_W = 8;

    // Dispatch sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        EMIT  = 2'd3
    } state_t;

endpackage

// File: rtl/nwd_fifo.sv
// Synchronous operand-pair FIFO with wrap-bit pointers.
// Latency: a pushed entry is visible on rd_dat_o the cycle after the push edge.
// Backpressure: full_o is registered-pointer based; no write while full even if popping.
module nwd_fifo
    import nwd_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = NWD_W,
    parameter int W2    = 2 * W
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          push_i,
    input  logic [W2-1:0] wr_dat_i,
    input  logic          pop_i,
    output logic [W2-1:0] rd_dat_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [W2-1:0] mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   rd_ptr_q;
    logic          do_push;
    logic          do_pop;

    // Same index with opposite wrap bits means every slot is occupied.
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rd_dat_o = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer update; reset discards all queued entries.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    // Storage write; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_dat_i;
    end

endmodule

// File: rtl/nwd_dispatch.sv
// Operand queue and sequencer feeding the nwd GCD core; zero operands resolved locally.
// Latency: bypass result 1 cycle after pop; core result 1 cycle after core_ready returns.
// Backpressure: result held in EMIT until res_ready; in_ready = !full of the operand FIFO.
module nwd_dispatch
    import nwd_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = NWD_W
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         in_valid,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         in_ready,
    output logic         core_start,
    output logic [W-1:0] core_a,
    output logic [W-1:0] core_b,
    input  logic         core_ready,
    input  logic [W-1:0] core_out,
    output logic         res_valid,
    output logic [W-1:0] res_data,
    input  logic         res_ready,
    output logic         busy
);

    state_t         state_q, state_d;
    logic [W-1:0]   op_a_q, op_a_d;
    logic [W-1:0]   op_b_q, op_b_d;
    logic [W-1:0]   res_q, res_d;

    logic           fifo_push;
    logic           fifo_pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [2*W-1:0] fifo_wr_dat;
    logic [2*W-1:0] fifo_rd_dat;
    logic [W-1:0]   head_a;
    logic [W-1:0]   head_b;

    assign fifo_push   = in_valid && !fifo_full;
    assign fifo_wr_dat = {in_a, in_b};
    assign head_a      = fifo_rd_dat[2*W-1:W];
    assign head_b      = fifo_rd_dat[W-1:0];

    nwd_fifo #(
        .DEPTH (DEPTH),
        .W     (W),
        .W2    (2 * W)
    ) u_fifo (
        .clk      (clk),
        .nrst     (nrst),
        .push_i   (fifo_push),
        .wr_dat_i (fifo_wr_dat),
        .pop_i    (fifo_pop),
        .rd_dat_o (fifo_rd_dat),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty)
    );

    assign in_ready  = !fifo_full;
    assign core_a    = op_a_q;
    assign core_b    = op_b_q;
    assign res_valid = (state_q == EMIT);
    assign res_data  = res_q;
    assign busy      = (state_q != IDLE);

    // Sequencer next state: pop, bypass zeros, issue to core, wait, emit.
    always_comb begin
        state_d    = state_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        res_d      = res_q;
        fifo_pop   = 1'b0;
        core_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    op_a_d   = head_a;
                    op_b_d   = head_b;
                    // The core never terminates on a zero operand; the GCD is the other one.
                    if ((head_a == '0) || (head_b == '0)) begin
                        res_d   = head_a | head_b;
                        state_d = EMIT;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                core_start = core_ready;
                if (core_ready) state_d = WAIT;
            end
            WAIT: begin
                // core_ready is low on the first WAIT cycle, so this is a fresh result.
                if (core_ready) begin
                    res_d   = core_out;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, operand and result registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            res_q   <= res_d;
        end
    end

endmodule

// File: tb/tb_nwd_dispatch.sv
// Self-checking bench for nwd_dispatch with a behavioural subtract-loop GCD core.
// Latency: n/a.
// Backpressure: res_ready driven directly and randomly.
module tb_nwd_dispatch;

    localparam int W     = 8;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         nrst;
    logic         in_valid;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_ready;
    logic         core_start;
    logic [W-1:0] core_a;
    logic [W-1:0] core_b;
    logic         core_ready;
    logic [W-1:0] core_out;
    logic         res_valid;
    logic [W-1:0] res_data;
    logic         res_ready;
    logic         busy;

    always #5 clk = ~clk;

    nwd_dispatch #(.DEPTH(DEPTH), .W(W)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .in_valid   (in_valid),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_ready   (in_ready),
        .core_start (core_start),
        .core_a     (core_a),
        .core_b     (core_b),
        .core_ready (core_ready),
        .core_out   (core_out),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_ready  (res_ready),
        .busy       (busy)
    );

    // Behavioural nwd core: loads on start, subtracts until equal, then reports.
    logic [W-1:0] m_a, m_b, m_out;
    logic         m_rdy;
    assign core_ready = m_rdy;
    assign core_out   = m_out;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            m_rdy <= 1'b1;
            m_out <= '0;
            m_a   <= '0;
            m_b   <= '0;
        end else if (m_rdy) begin
            if (core_start) begin
                m_a   <= core_a;
                m_b   <= core_b;
                m_rdy <= 1'b0;
            end
        end else if (m_a == m_b) begin
            m_rdy <= 1'b1;
            m_out <= m_a;
        end else if (m_a > m_b) begin
            m_a <= m_a - m_b;
        end else begin
            m_b <= m_b - m_a;
        end
    end

    // Observation of accepted results, start pulses and valid cycles, mid-cycle.
    logic [W-1:0] obs_q[$];
    int           starts  = 0;
    int           rv_cyc  = 0;
    always @(negedge clk) begin
        if (nrst) begin
            if (res_valid && res_ready) obs_q.push_back(res_data);
            if (core_start) starts = starts + 1;
            if (res_valid) rv_cyc = rv_cyc + 1;
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int gcd_ref(input int a, input int b);
        int x = a;
        int y = b;
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int a, input int b);
        int n = 0;
        in_valid = 1'b1;
        in_a     = 8'(a);
        in_b     = 8'(b);
        while (!in_ready && n < 5000) begin
            step();
            n++;
        end
        check("push_accept", 32'(n < 5000), 1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_obs(input int n);
        int c = 0;
        while (obs_q.size() < n && c < 20000) begin
            step();
            c++;
        end
        check("wait_result", 32'(obs_q.size() >= n), 1);
    endtask

    initial begin
        int s0;
        int rd;
        int rv0;
        int ra[8];
        int rb[8];
        int ex[8];
        int bp_a[5] = '{48, 15, 7, 24, 9};
        int bp_b[5] = '{18, 10, 3, 36, 6};

        nrst      = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",   32'(in_ready),   1);
        check("rst_core_start", 32'(core_start), 0);
        check("rst_core_a",     32'(core_a),     0);
        check("rst_core_b",     32'(core_b),     0);
        check("rst_res_valid",  32'(res_valid),  0);
        check("rst_res_data",   32'(res_data),   0);
        check("rst_busy",       32'(busy),       0);
        nrst = 1'b1;
        step();

        // (48,18) through the core with the consumer always ready.
        res_ready = 1'b1;
        s0 = starts;
        rd = obs_q.size();
        push(48, 18);
        wait_obs(rd + 1);
        check("gcd_48_18", 32'(obs_q[rd]), 6);
        check("start_once", 32'(starts - s0), 1);
        check("busy_after_accept", 32'(busy), 0);

        // Zero-operand bypass: result one cycle after the pop, no core start.
        res_ready = 1'b0;
        s0 = starts;
        rd = obs_q.size();
        push(0, 7);
        check("byp07_not_yet", 32'(res_valid), 0);
        step();
        check("byp07_valid", 32'(res_valid), 1);
        check("byp07_data",  32'(res_data),  7);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        push(0, 0);
        check("byp00_not_yet", 32'(res_valid), 0);
        step();
        check("byp00_valid", 32'(res_valid), 1);
        check("byp00_data",  32'(res_data),  0);
        res_ready = 1'b1;
        step();
        check("byp_no_start", 32'(starts - s0), 0);
        check("byp_order_0", 32'(obs_q[rd]), 7);
        check("byp_order_1", 32'(obs_q[rd + 1]), 0);

        // (9,9): res_valid rises exactly four edges after the push edge.
        res_ready = 1'b0;
        push(9, 9);
        step();
        step();
        step();
        check("lat99_e3", 32'(res_valid), 0);
        step();
        check("lat99_e4", 32'(res_valid), 1);
        check("lat99_data", 32'(res_data), 9);
        res_ready = 1'b1;
        step();

        // Backpressure: hold the consumer, fill the FIFO behind the active pair.
        res_ready = 1'b0;
        rd = obs_q.size();
        for (int i = 0; i < 5; i++) push(bp_a[i], bp_b[i]);
        check("bp_full", 32'(in_ready), 0);
        repeat (100) step();
        check("bp_valid", 32'(res_valid), 1);
        check("bp_hold_0", 32'(res_data), 6);
        repeat (10) step();
        check("bp_hold_1", 32'(res_data), 6);
        check("bp_still_full", 32'(in_ready), 0);
        res_ready = 1'b1;
        wait_obs(rd + 5);
        for (int i = 0; i < 5; i++)
            check("bp_drain", 32'(obs_q[rd + i]), 32'(gcd_ref(bp_a[i], bp_b[i])));

        // Reset while the core grinds through (255,1).
        push(255, 1);
        repeat (5) step();
        check("mid_busy", 32'(busy), 1);
        check("mid_core_a", 32'(core_a), 255);
        nrst = 1'b0;
        #1;
        check("mrst_in_ready",   32'(in_ready),   1);
        check("mrst_core_start", 32'(core_start), 0);
        check("mrst_core_a",     32'(core_a),     0);
        check("mrst_core_b",     32'(core_b),     0);
        check("mrst_res_valid",  32'(res_valid),  0);
        check("mrst_res_data",   32'(res_data),   0);
        check("mrst_busy",       32'(busy),       0);
        step();
        step();
        nrst = 1'b1;
        rv0 = rv_cyc;
        repeat (300) step();
        check("mrst_no_valid", 32'(rv_cyc - rv0), 0);
        rd = obs_q.size();
        push(100, 75);
        wait_obs(rd + 1);
        check("gcd_100_75", 32'(obs_q[rd]), 25);

        // Random nonzero stream with random consumer readiness.
        for (int i = 0; i < 8; i++) begin
            ra[i] = $urandom_range(1, 255);
            rb[i] = $urandom_range(1, 255);
            ex[i] = gcd_ref(ra[i], rb[i]);
        end
        s0 = starts;
        rd = obs_q.size();
        fork
            begin
                for (int i = 0; i < 8; i++) push(ra[i], rb[i]);
            end
            begin
                int c = 0;
                while (obs_q.size() < rd + 8 && c < 20000) begin
                    res_ready = 1'($urandom_range(0, 1));
                    step();
                    c++;
                end
                res_ready = 1'b1;
            end
        join
        check("rnd_count", 32'(obs_q.size() - rd), 8);
        for (int i = 0; i < 8; i++) begin
            if (rd + i < obs_q.size())
                check("rnd_result", 32'(obs_q[rd + i]), 32'(ex[i]));
            else
                check("rnd_missing", 0, 32'(ex[i]));
        end
        check("rnd_starts", 32'(starts - s0), 8);
        check("rnd_idle", 32'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
